// File: rtl/mse_bus_sequencer.sv
// Round-robin bus master for the shared MSE parallel bus: setup/strobe/hold/turn sequencing.
// Build option MSE_BUS_WAIT_EN adds bus_wait strobe extension with a 255-cycle timeout (bus_err).
module mse_bus_sequencer #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned TURN_CYC   = 1
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [1:0]  req,
    input  logic [1:0]  req_wr,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef MSE_BUS_WAIT_EN
    input  logic        bus_wait,
    output logic        bus_err,
`endif
    output logic [1:0]  ack,
    output logic [15:0] rdata,
    output logic        busy,
    inout  wire  [15:0] data,
    output logic [15:0] data_dir,
    inout  wire  [7:0]  address,
    output logic [7:0]  address_dir,
    inout  wire         wr,
    output logic        wr_dir,
    inout  wire         rd,
    output logic        rd_dir
);

    localparam logic [3:0] L_SETUP  = 4'(SETUP_CYC);
    localparam logic [3:0] L_STROBE = 4'(STROBE_CYC);
    localparam logic [3:0] L_HOLD   = 4'(HOLD_CYC);
    localparam logic [3:0] L_TURN   = 4'(TURN_CYC);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StTurn} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_last;
    logic        r_sel;
    logic        r_is_wr;
    logic [7:0]  r_addr;
    logic [15:0] r_wdata;
    logic        r_own;
    logic [1:0]  r_ack;
    logic [15:0] r_rdata;
    logic        w_gnt;
    logic        w_hold;
    logic        w_timeout;
    logic        w_strobe_end;
    logic        w_hold_end;
    logic        w_drive;
    logic        w_wr_o;
    logic        w_rd_o;

    // Requester not granted last wins a tie; a lone requester always wins.
    assign w_gnt = (req == 2'b11) ? ~r_last : req[1];

`ifdef MSE_BUS_WAIT_EN
    logic       r_wait_meta;
    logic       r_wait_sync;
    logic [7:0] r_ext;
    logic       r_err_pend;
    logic       r_bus_err;

    assign w_hold    = (r_state == StStrobe) && (r_cnt == 4'd1) && r_wait_sync && (r_ext != 8'hFF);
    assign w_timeout = (r_state == StStrobe) && (r_cnt == 4'd1) && r_wait_sync && (r_ext == 8'hFF);
    assign bus_err   = r_bus_err;

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_wait_meta <= 1'b0;
            r_wait_sync <= 1'b0;
            r_ext       <= 8'd0;
            r_err_pend  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_wait_meta <= bus_wait;
            r_wait_sync <= r_wait_meta;
            if (r_state != StStrobe) begin
                r_ext <= 8'd0;
            end else if (w_hold) begin
                r_ext <= r_ext + 8'd1;
            end
            if (w_timeout) begin
                r_err_pend <= 1'b1;
            end else if (r_state == StIdle) begin
                r_err_pend <= 1'b0;
            end
            r_bus_err <= w_hold_end && r_err_pend;
        end
    end
`else
    assign w_hold    = 1'b0;
    assign w_timeout = 1'b0;
`endif

    assign w_strobe_end = (r_state == StStrobe) && (r_cnt == 4'd1) && !w_hold;
    assign w_hold_end   = (r_state == StHold) && (r_cnt == 4'd1);

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt > 4'd1) ? r_cnt - 4'd1 : r_cnt;
        unique case (r_state)
            StIdle: begin
                if (|req) begin
                    w_state_nxt = StSetup;
                    w_cnt_nxt   = L_SETUP;
                end
            end
            StSetup: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = StStrobe;
                    w_cnt_nxt   = L_STROBE;
                end
            end
            StStrobe: begin
                if (w_strobe_end) begin
                    w_state_nxt = StHold;
                    w_cnt_nxt   = L_HOLD;
                end
            end
            StHold: begin
                if (r_cnt == 4'd1) begin
                    if (r_is_wr && (L_TURN != 4'd0)) begin
                        w_state_nxt = StTurn;
                        w_cnt_nxt   = L_TURN;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            StTurn: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_drive = 1'b0;
        w_wr_o  = 1'b0;
        w_rd_o  = 1'b0;
        unique case (r_state)
            StSetup, StHold: w_drive = r_is_wr;
            StStrobe: begin
                w_drive = r_is_wr;
                w_wr_o  = r_is_wr;
                w_rd_o  = !r_is_wr;
            end
            default: w_drive = 1'b0;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
            r_is_wr <= 1'b0;
            r_addr  <= 8'd0;
            r_wdata <= 16'd0;
            r_own   <= 1'b0;
            r_ack   <= 2'b00;
            r_rdata <= 16'd0;
        end else begin
            r_ack <= 2'b00;
            if ((r_state == StIdle) && (|req)) begin
                r_sel   <= w_gnt;
                r_last  <= w_gnt;
                r_is_wr <= req_wr[w_gnt];
                r_addr  <= w_gnt ? req_addr[15:8] : req_addr[7:0];
                r_wdata <= w_gnt ? req_wdata[31:16] : req_wdata[15:0];
                r_own   <= 1'b1;
            end
            if (w_timeout) begin
                r_rdata <= 16'hFFFF;
            end else if (w_strobe_end && !r_is_wr) begin
                r_rdata <= data;
            end
            if (w_hold_end) begin
                r_ack <= r_sel ? 2'b10 : 2'b01;
            end
        end
    end

    assign ack         = r_ack;
    assign rdata       = r_rdata;
    assign busy        = (r_state != StIdle);
    assign data_dir    = {16{w_drive}};
    assign address_dir = {8{r_own}};
    assign wr_dir      = r_own;
    assign rd_dir      = r_own;

    for (genvar i = 0; i < 16; i++) begin : g_data
        assign data[i] = data_dir[i] ? r_wdata[i] : 1'bz;
    end
    for (genvar i = 0; i < 8; i++) begin : g_addr
        assign address[i] = address_dir[i] ? r_addr[i] : 1'bz;
    end
    assign wr = wr_dir ? w_wr_o : 1'bz;
    assign rd = rd_dir ? w_rd_o : 1'bz;

endmodule

// File: tb/tb_mse_bus_sequencer.sv
// Scoreboard bench for mse_bus_sequencer: default instance plus a 3/4/2/0 timing instance.
module tb_mse_bus_sequencer;

    logic clk;
    logic rst;

    logic [1:0]  a_req, a_req_wr, a_ack;
    logic [15:0] a_req_addr, a_rdata, a_data_dir;
    logic [31:0] a_req_wdata;
    logic        a_busy, a_wr_dir, a_rd_dir;
    logic [7:0]  a_address_dir;
    wire  [15:0] a_data;
    wire  [7:0]  a_address;
    wire         a_wr, a_rd;

    logic [1:0]  b_req, b_req_wr, b_ack;
    logic [15:0] b_req_addr, b_rdata, b_data_dir;
    logic [31:0] b_req_wdata;
    logic        b_busy, b_wr_dir, b_rd_dir;
    logic [7:0]  b_address_dir;
    wire  [15:0] b_data;
    wire  [7:0]  b_address;
    wire         b_wr, b_rd;

    logic        tb_drv;
    logic [15:0] tb_rdval;

`ifdef MSE_BUS_WAIT_EN
    logic a_bus_wait, a_bus_err, b_bus_wait, b_bus_err;
`endif

    assign a_data = tb_drv ? tb_rdval : 16'bz;

    mse_bus_sequencer u_dut_a (
        .csi_MCLK_clk   (clk),
        .rsi_MRST_reset (rst),
        .req            (a_req),
        .req_wr         (a_req_wr),
        .req_addr       (a_req_addr),
        .req_wdata      (a_req_wdata),
`ifdef MSE_BUS_WAIT_EN
        .bus_wait       (a_bus_wait),
        .bus_err        (a_bus_err),
`endif
        .ack            (a_ack),
        .rdata          (a_rdata),
        .busy           (a_busy),
        .data           (a_data),
        .data_dir       (a_data_dir),
        .address        (a_address),
        .address_dir    (a_address_dir),
        .wr             (a_wr),
        .wr_dir         (a_wr_dir),
        .rd             (a_rd),
        .rd_dir         (a_rd_dir)
    );

    mse_bus_sequencer #(
        .SETUP_CYC  (3),
        .STROBE_CYC (4),
        .HOLD_CYC   (2),
        .TURN_CYC   (0)
    ) u_dut_b (
        .csi_MCLK_clk   (clk),
        .rsi_MRST_reset (rst),
        .req            (b_req),
        .req_wr         (b_req_wr),
        .req_addr       (b_req_addr),
        .req_wdata      (b_req_wdata),
`ifdef MSE_BUS_WAIT_EN
        .bus_wait       (b_bus_wait),
        .bus_err        (b_bus_err),
`endif
        .ack            (b_ack),
        .rdata          (b_rdata),
        .busy           (b_busy),
        .data           (b_data),
        .data_dir       (b_data_dir),
        .address        (b_address),
        .address_dir    (b_address_dir),
        .wr             (b_wr),
        .wr_dir         (b_wr_dir),
        .rd             (b_rd),
        .rd_dir         (b_rd_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0]  ack;
        logic        is_rd;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb[$];

    // Every ack on instance A must match the oldest expected completion.
    always @(negedge clk) begin
        if (!rst && (a_ack != 2'b00)) begin
            check("ack_onehot", 32'($onehot(a_ack)), 1);
            if (sb.size() == 0) begin
                check("ack_unexpected", 32'(a_ack), 0);
            end else begin
                check("sb_ack", 32'(a_ack), 32'(sb[0].ack));
                if (sb[0].is_rd) check("sb_rdata", 32'(a_rdata), 32'(sb[0].rdata));
                sb.delete(0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        tb_drv = 1'b0;
        tb_rdval = 16'h5A5A;
        a_req = 2'b00; a_req_wr = 2'b00; a_req_addr = 16'h0; a_req_wdata = 32'h0;
        b_req = 2'b00; b_req_wr = 2'b00; b_req_addr = 16'h0; b_req_wdata = 32'h0;
`ifdef MSE_BUS_WAIT_EN
        a_bus_wait = 1'b0;
        b_bus_wait = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_data_dir", 32'(a_data_dir), 0);
        check("rst_addr_dir", 32'(a_address_dir), 0);
        check("rst_wr_dir", 32'(a_wr_dir), 0);
        check("rst_rd_dir", 32'(a_rd_dir), 0);
        check("rst_ack", 32'(a_ack), 0);
        check("rst_rdata", 32'(a_rdata), 0);
        check("rst_busy", 32'(a_busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Write from requester 0 at cycle 0.
        a_req = 2'b01; a_req_wr = 2'b01; a_req_addr = 16'h0012; a_req_wdata = 32'h0000_A5C3;
        sb.push_back(exp_t'{ack: 2'b01, is_rd: 1'b0, rdata: 16'h0});
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a_req = 2'b00;
                check("t1_addr_dir", 32'(a_address_dir), 'hFF);
                check("t1_wr_dir", 32'(a_wr_dir), 1);
                check("t1_rd_dir", 32'(a_rd_dir), 1);
                check("t1_address", 32'(a_address), 'h12);
                check("t1_data", 32'(a_data), 'hA5C3);
            end
            if (c <= 4) begin
                check("t1_data_dir", 32'(a_data_dir), 'hFFFF);
                check("t1_wr", 32'(a_wr), 32'((c == 2) || (c == 3)));
            end
            if (c == 5) begin
                check("t1_data_dir_rel", 32'(a_data_dir), 0);
                check("t1_ack", 32'(a_ack), 'b01);
                check("t1_rdata_hold", 32'(a_rdata), 0);
            end
        end

        // Read from requester 1; bench drives the data bus.
        a_req = 2'b10; a_req_wr = 2'b00; a_req_addr = 16'h3400; tb_drv = 1'b1;
        sb.push_back(exp_t'{ack: 2'b10, is_rd: 1'b1, rdata: 16'h5A5A});
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a_req = 2'b00;
                check("t2_address", 32'(a_address), 'h34);
            end
            check("t2_data_dir", 32'(a_data_dir), 0);
            if (c <= 4) check("t2_rd", 32'(a_rd), 32'((c == 2) || (c == 3)));
            if (c == 5) begin
                check("t2_ack", 32'(a_ack), 'b10);
                check("t2_rdata", 32'(a_rdata), 'h5A5A);
            end
        end
        @(negedge clk);

        // Both requesters held: grants must alternate 0,1,0,1.
        tb_rdval = 16'h3C3C;
        a_req = 2'b11; a_req_wr = 2'b00; a_req_addr = 16'h5678;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(exp_t'{ack: (k % 2 == 0) ? 2'b01 : 2'b10, is_rd: 1'b1, rdata: 16'h3C3C});
        end
        n = 0;
        for (int k = 0; (k < 60) && (n < 4); k++) begin
            @(negedge clk);
            if (a_ack != 2'b00) begin
                n++;
                if (n == 4) a_req = 2'b00;
            end
        end
        check("t3_ack_count", 32'(n), 4);
        tb_drv = 1'b0;
        @(negedge clk);

        // Reset during STROBE of a write aborts with no ack.
        a_req = 2'b01; a_req_wr = 2'b01; a_req_addr = 16'h0056; a_req_wdata = 32'h0000_1111;
        @(negedge clk);
        a_req = 2'b00;
        @(negedge clk);
        check("t4_wr_before", 32'(a_wr), 1);
        rst = 1'b1;
        #1;
        check("t4_data_dir", 32'(a_data_dir), 0);
        check("t4_addr_dir", 32'(a_address_dir), 0);
        check("t4_wr_dir", 32'(a_wr_dir), 0);
        check("t4_rd_dir", 32'(a_rd_dir), 0);
        check("t4_busy", 32'(a_busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        a_req = 2'b01; a_req_wr = 2'b01; a_req_addr = 16'h0078; a_req_wdata = 32'h0000_BEEF;
        sb.push_back(exp_t'{ack: 2'b01, is_rd: 1'b0, rdata: 16'h0});
        n = 0;
        for (int k = 1; (k < 20) && (n == 0); k++) begin
            @(negedge clk);
            if (k == 1) begin
                a_req = 2'b00;
                check("t4_regrant_addr_dir", 32'(a_address_dir), 'hFF);
            end
            if (a_ack != 2'b00) n = 1;
        end
        check("t4_ack_seen", 32'(n), 1);

        // Instance B: back-to-back write then read from requester 0.
        @(negedge clk);
        b_req = 2'b01; b_req_wr = 2'b01; b_req_addr = 16'h009A; b_req_wdata = 32'h0000_1234;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 1) b_req_wr = 2'b00;
            if (c == 4) check("b_wr_strobe", 32'(b_wr), 1);
            if (c == 8) begin
                check("b_wr_hold", 32'(b_wr), 0);
                check("b_data_dir_hold", 32'(b_data_dir), 'hFFFF);
            end
            if (c == 9) check("b_ack_c9", 32'(b_ack), 0);
            if (c == 10) begin
                check("b_ack_c10", 32'(b_ack), 'b01);
                check("b_busy_c10", 32'(b_busy), 0);
            end
            if (c == 11) begin
                check("b_busy_c11", 32'(b_busy), 1);
                check("b_data_dir_c11", 32'(b_data_dir), 0);
                b_req = 2'b00;
            end
            if (c == 13) check("b_rd_c13", 32'(b_rd), 0);
            if (c == 14) check("b_rd_c14", 32'(b_rd), 1);
            if (c == 17) check("b_rd_c17", 32'(b_rd), 1);
            if (c == 18) check("b_rd_c18", 32'(b_rd), 0);
            if (c == 19) check("b_ack_c19", 32'(b_ack), 0);
            if (c == 20) check("b_ack_c20", 32'(b_ack), 'b01);
            if (c == 21) check("b_busy_c21", 32'(b_busy), 0);
        end

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mse_bus_sequencer.md
Name: mse_bus_sequencer

Overview:
- Bus master and arbiter for the shared MSE parallel bus: 16-bit data, 8-bit address, wr/rd strobes, each with per-bit direction control.
- Accepts single-word read/write requests from two internal requesters (0: Avalon slave bridge, 1: MSE serial engine) and arbitrates round-robin.
- Sequences each granted access as setup/strobe/hold phases, drives the direction lines and returns read data plus a one-cycle ack.

Parameters:
- SETUP_CYC, 1: cycles address/data are driven before the strobe; range 1..15.
- STROBE_CYC, 2: cycles wr or rd is held active; range 1..15.
- HOLD_CYC, 1: cycles address/data are held after the strobe; range 1..15.
- TURN_CYC, 1: idle cycles after a write before any new grant; data bus released; range 0..15.

Ports:
- csi_MCLK_clk  in  1  clock, single domain
- rsi_MRST_reset  in  1  asynchronous, active-high reset
- req  in  2  per-requester request, level
- req_wr  in  2  per-requester access type: 1 = write, 0 = read
- req_addr  in  16  {addr1[7:0], addr0[7:0]}
- req_wdata  in  32  {wdata1[15:0], wdata0[15:0]}
- ack  out  2  one-cycle completion pulse, one-hot
- rdata  out  16  read data, valid when ack is high
- busy  out  1  high whenever the state is not IDLE
- data  inout  16  shared bus data
- data_dir  out  16  per bit: 1 = drive, 0 = release
- address  inout  8  shared bus address
- address_dir  out  8  per bit: 1 = drive
- wr  inout  1  write strobe, active high
- wr_dir  out  1  1 = drive wr
- rd  inout  1  read strobe, active high
- rd_dir  out  1  1 = drive rd

Behaviour:
- Reset values: all *_dir = 0; ack = 0; rdata = 0; busy = 0; internal wr/rd/address/data outputs = 0; state = IDLE; round-robin pointer selects requester 0 first.
- Reset is asynchronous and may arrive mid-transaction. The sequencer aborts at once, releases all lines and issues no ack.
- First grant after reset sets address_dir = 8'hFF, wr_dir = 1 and rd_dir = 1. These stay 1 until the next reset (bus master owns address and strobes).
- States and transitions:
  - IDLE: on any req, grant per round-robin and go to SETUP. The granted requester's wr/addr/wdata are latched in this cycle, so later changes are ignored.
  - SETUP: address driven. On a write, data_dir = 16'hFFFF and data = wdata. Lasts SETUP_CYC cycles.
  - STROBE: wr = 1 (write) or rd = 1 (read). Lasts STROBE_CYC cycles. On a read, data is sampled into rdata on the last STROBE cycle.
  - HOLD: strobe = 0, address and data still held. Lasts HOLD_CYC cycles. On exit, ack[granted] = 1 for exactly one cycle.
  - TURN: data_dir = 0. Lasts TURN_CYC cycles, entered only after a write (skipped when TURN_CYC = 0), then IDLE.
  - A read goes from HOLD directly to IDLE. data_dir stays 0 for the whole read.
- Latency, defaults, req sampled in IDLE at cycle 0: SETUP cycle 1, STROBE cycles 2-3, HOLD cycle 4, ack at cycle 5. Next grant is at the earliest cycle 5 for a read, cycle 6 for a write.
- Round-robin: if both req are high in IDLE, grant the requester not granted last. With a single requester, it is always granted.
- A requester deasserting req mid-transaction does not abort the access; ack is still issued.
- A requester keeping req high after its ack is treated as a new request.
- Phase counters are 4-bit and reload at each phase entry; no wrap-around is possible within parameter ranges.
- rdata holds its last value until the next read capture.

Optional Feature:
- Macro: MSE_BUS_WAIT_EN.
- Defined: adds input port bus_wait (1 bit), synchronized by two flops. While the synchronized bus_wait is high, STROBE is extended, and its final-cycle counter stays at 1.
  - After 255 extension cycles the access terminates. Read data is captured as 16'hFFFF, and output bus_err pulses together with ack.
- Undefined: no bus_wait or bus_err ports; STROBE is exactly STROBE_CYC cycles.

Test Plan:
- Reset then write, req0 with addr 8'h12, wdata 16'hA5C3, defaults -> first grant sets address_dir 8'hFF, wr_dir 1, rd_dir 1; data_dir 16'hFFFF cycles 1-4; wr high cycles 2-3; ack 2'b01 at cycle 5; data_dir 0 at cycle 5.
- Read, req1 with addr 8'h34, bench drives data 16'h5A5A while rd high -> rdata 16'h5A5A with ack 2'b10 at cycle 5; data_dir stays 0 throughout.
- Both req held high for 4 transactions -> grant order 0,1,0,1; never two acks in the same cycle.
- Assert reset during STROBE of a write -> all *_dir 0 and wr 0 in the same cycle; no ack; after release, a new req0 completes normally.
- SETUP_CYC=3, STROBE_CYC=4, HOLD_CYC=2, TURN_CYC=0, back-to-back write then read from req0 -> ack at cycles 10 and 20; the read's SETUP starts at cycle 11.
- MSE_BUS_WAIT_EN defined, bus_wait held high 5 cycles into STROBE -> strobe width extended by those cycles, no bus_err. Held permanently -> ack with bus_err 1 and rdata 16'hFFFF.
